// File: rtl/game_engine_ue_pkg.sv
// Shared cell/state codes, BCD saturation value and LFSR step for the unicorn game engine.
package game_engine_ue_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_LOW   = 2'd1,
        CELL_HIGH  = 2'd2
    } cell_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    localparam logic [31:0] BCD_SAT = 32'h9999_9999;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/game_engine_ue_bcd_counter8.sv
// 8-digit packed-BCD incrementer, one-cycle update, saturating at 9999_9999.
module bcd_counter8
    import game_engine_ue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] q
);
    logic [31:0] q_q;
    logic [31:0] q_d;
    logic [31:0] inc_val;

    always_comb begin
        logic carry;
        carry   = 1'b1;
        inc_val = q_q;
        for (int k = 0; k < 8; k++) begin
            if (carry) begin
                if (q_q[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = q_q[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != BCD_SAT)) begin
            q_d = inc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/game_engine_ue.sv
// Unicorn game state: button sync, IDLE/RUN/DEAD FSM, scrolling obstacle map, jump timer, BCD score.
// Button presses act 3 cycles after the pin edge; start/dead follow the state one cycle later.
module game_engine_ue
    import game_engine_ue_pkg::*;
#(
    parameter int          TICK_DIV   = 50_000_000,
    parameter int          JUMP_TICKS = 2,
    parameter int          MIN_GAP    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_jump,
    output logic [15:0] map,
    output logic        start,
    output logic        jump,
    output logic        dead,
    output logic [31:0] score
);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [7:0]  JUMP_LOAD = 8'(JUMP_TICKS);
    localparam logic [7:0]  GAP_LOAD  = 8'(MIN_GAP);

    logic [2:0]  start_sync_q, jump_sync_q;
    logic        start_edge, jump_edge;
    state_e      state_q, state_d;
    logic [15:0] map_q, map_d;
    logic        jump_q, jump_d;
    logic [7:0]  jcnt_q, jcnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic        start_q, dead_q;
    logic        tick, collision;
    logic        score_clr, score_inc;
    cell_e       gen;

    // Two synchronizer flops, the third holds the previous level for edge detection
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            start_sync_q <= '0;
            jump_sync_q  <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], btn_start};
            jump_sync_q  <= {jump_sync_q[1:0], btn_jump};
        end
    end

    assign start_edge = start_sync_q[1] & ~start_sync_q[2];
    assign jump_edge  = jump_sync_q[1] & ~jump_sync_q[2];
    assign tick       = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
    assign collision  = (state_q == ST_RUN) &&
                        ((map_q[15:14] == CELL_LOW && !jump_q) ||
                         (map_q[15:14] == CELL_HIGH && jump_q));

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        jump_d     = jump_q;
        jcnt_d     = jcnt_q;
        gap_d      = gap_q;
        lfsr_d     = lfsr_q;
        tick_cnt_d = tick_cnt_q;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        gen        = CELL_EMPTY;
        if (gap_q == 8'd0) begin
            unique case (lfsr_q[1:0])
                2'd1:    gen = CELL_LOW;
                2'd2:    gen = CELL_HIGH;
                default: gen = CELL_EMPTY;
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                    jump_d     = 1'b0;
                    score_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                // A collision freezes everything, including a coincident tick
                if (collision) begin
                    state_d = ST_DEAD;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
                    if (jump_edge && !jump_q) begin
                        jump_d = 1'b1;
                        jcnt_d = JUMP_LOAD;
                    end else if (tick && jump_q) begin
                        if (jcnt_q == 8'd1) jump_d = 1'b0;
                        else                jcnt_d = jcnt_q - 8'd1;
                    end
                    if (tick) begin
                        map_d     = {map_q[13:0], gen};
                        lfsr_d    = lfsr_step(lfsr_q);
                        score_inc = 1'b1;
                        if (gap_q != 8'd0)           gap_d = gap_q - 8'd1;
                        else if (gen != CELL_EMPTY) gap_d = GAP_LOAD;
                    end
                end
            end
            ST_DEAD: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                    map_d   = '0;
                    jump_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            map_q      <= '0;
            jump_q     <= 1'b0;
            jcnt_q     <= '0;
            gap_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            tick_cnt_q <= '0;
            start_q    <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_q      <= map_d;
            jump_q     <= jump_d;
            jcnt_q     <= jcnt_d;
            gap_q      <= gap_d;
            lfsr_q     <= lfsr_d;
            tick_cnt_q <= tick_cnt_d;
            start_q    <= (state_q == ST_RUN);
            dead_q     <= (state_q == ST_DEAD);
        end
    end

    bcd_counter8 u_score (
        .clk   (CLK100MHZ),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .q     (score)
    );

    assign map   = map_q;
    assign jump  = jump_q;
    assign start = start_q;
    assign dead  = dead_q;

endmodule

// File: tb/tb_game_engine_ue.sv
// Bench for game_engine_ue: scenario tasks plus a tick-level game model with decimal score.
module tb_game_engine_ue;
    localparam int TICK_DIV   = 4;
    localparam int JUMP_TICKS = 2;
    localparam int MIN_GAP    = 2;

    logic        CLK100MHZ;
    logic        reset;
    logic        btn_start;
    logic        btn_jump;
    logic [15:0] map;
    logic        start;
    logic        jump;
    logic        dead;
    logic [31:0] score;
    logic [50:0] dut_vec;

    int tests = 0;
    int fails = 0;

    game_engine_ue #(
        .TICK_DIV   (TICK_DIV),
        .JUMP_TICKS (JUMP_TICKS),
        .MIN_GAP    (MIN_GAP),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_jump  (btn_jump),
        .map       (map),
        .start     (start),
        .jump      (jump),
        .dead      (dead),
        .score     (score)
    );

    assign dut_vec = {map, start, jump, dead, score};

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Game model: 0=idle 1=running 2=over; cells hold obstacle codes, score is a plain integer
    int          m_state;
    int          m_cell [8];
    int          m_score;
    logic [15:0] m_lfsr;
    int          m_gap, m_div, m_air;
    bit          m_jump, m_start_o, m_dead_o, m_ticked;
    bit          sd1, sd2, jd1, jd2;
    bit          last_ps, last_pj;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [50:0] m_vec();
        logic [15:0] mp;
        mp = '0;
        for (int i = 0; i < 8; i++) mp[2*i +: 2] = 2'(m_cell[i]);
        return {mp, m_start_o, m_jump, m_dead_o, to_bcd(m_score)};
    endfunction

    function automatic void model_edge(input bit rs, input bit ps, input bit pj);
        bit ev_s, ev_j, hit, tk;
        int gen;
        m_ticked = 1'b0;
        if (rs) begin
            m_state = 0;
            for (int i = 0; i < 8; i++) m_cell[i] = 0;
            m_score = 0; m_lfsr = 16'hACE1; m_gap = 0; m_div = 0; m_air = 0;
            m_jump = 0; m_start_o = 0; m_dead_o = 0;
            sd1 = 0; sd2 = 0; jd1 = 0; jd2 = 0;
            return;
        end
        // a press is acted on at the third clock edge after it is driven
        ev_s = sd2; sd2 = sd1; sd1 = ps;
        ev_j = jd2; jd2 = jd1; jd1 = pj;
        m_start_o = (m_state == 1);
        m_dead_o  = (m_state == 2);
        if (m_state == 0) begin
            if (ev_s) begin
                m_state = 1; m_score = 0; m_div = 0; m_jump = 0;
            end
        end else if (m_state == 1) begin
            hit = (m_cell[7] == 1 && !m_jump) || (m_cell[7] == 2 && m_jump);
            if (hit) begin
                m_state = 2;
            end else begin
                tk = (m_div == TICK_DIV - 1);
                m_div = tk ? 0 : m_div + 1;
                if (ev_j && !m_jump) begin
                    m_jump = 1; m_air = JUMP_TICKS;
                end else if (tk && m_jump) begin
                    m_air = m_air - 1;
                    if (m_air == 0) m_jump = 0;
                end
                if (tk) begin
                    gen = 0;
                    if (m_gap > 0) begin
                        m_gap = m_gap - 1;
                    end else begin
                        gen = (m_lfsr % 4 == 1) ? 1 : (m_lfsr % 4 == 2) ? 2 : 0;
                        if (gen != 0) m_gap = MIN_GAP;
                    end
                    for (int i = 7; i > 0; i--) m_cell[i] = m_cell[i-1];
                    m_cell[0] = gen;
                    if (m_score < 99999999) m_score = m_score + 1;
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                    m_ticked = 1'b1;
                end
            end
        end else begin
            if (ev_s) begin
                m_state = 0; m_jump = 0;
                for (int i = 0; i < 8; i++) m_cell[i] = 0;
            end
        end
    endfunction

    // mode 0: clear lows, 1: never jump, 2: jump at any obstacle, 3: random presses
    function automatic bit bot_press(input int mode);
        if (last_pj) return 1'b0;
        if (mode == 3) return ($urandom_range(0, 5) == 0);
        if (m_state != 1 || m_jump || !m_ticked) return 1'b0;
        if (mode == 0) return (m_cell[6] == 1);
        if (mode == 2) return (m_cell[6] != 0);
        return 1'b0;
    endfunction

    task automatic step(input bit rs, input bit ps, input bit pj);
        reset = rs; btn_start = ps; btn_jump = pj;
        last_ps = ps; last_pj = pj;
        @(posedge CLK100MHZ);
        model_edge(rs, ps, pj);
        @(negedge CLK100MHZ);
    endtask

    task automatic begin_game();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec !== 51'd0) begin
            fails++; $display("FAIL reset_values: got %h want 0", dut_vec);
        end
        repeat (6) step(1'b0, 1'b0, 1'b0);
        tests++;
        if (start !== 1'b0 || dead !== 1'b0 || map !== 16'h0) begin
            fails++; $display("FAIL reset_press_ignored: start=%b dead=%b map=%h want 0/0/0", start, dead, map);
        end
    endtask

    task automatic test_start();
        int n;
        bit bad_code;
        step(1'b0, 1'b1, 1'b0);
        n = 1;
        while (start !== 1'b1 && n < 4) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        tests++;
        if (start !== 1'b1) begin
            fails++; $display("FAIL start_latency: start=%b after %0d cycles want 1", start, n);
        end
        bad_code = 1'b0;
        repeat (32) begin
            step(1'b0, 1'b0, bot_press(0));
            for (int i = 0; i < 8; i++) if (map[2*i +: 2] == 2'd3) bad_code = 1'b1;
            tests++;
            if (dut_vec !== m_vec()) begin
                fails++; $display("FAIL start_track: dut=%h model=%h", dut_vec, m_vec());
            end
        end
        tests++;
        if (score !== 32'h0000_0008 || bad_code) begin
            fails++; $display("FAIL start_score: score=%h code3=%b want 00000008/0", score, bad_code);
        end
    endtask

    task automatic test_collision_low();
        int n;
        logic [50:0] frozen;
        begin_game();
        n = 0;
        while (dead !== 1'b1 && n < 800) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            tests++;
            if (dut_vec !== m_vec()) begin
                fails++; $display("FAIL low_track: dut=%h model=%h", dut_vec, m_vec());
            end
        end
        tests++;
        if (dead !== 1'b1 || map[15:14] !== 2'd1 || jump !== 1'b0) begin
            fails++; $display("FAIL low_hit: dead=%b cell7=%0d jump=%b want 1/1/0", dead, map[15:14], jump);
        end
        frozen = m_vec();
        repeat (12) step(1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_vec !== frozen) begin
            fails++; $display("FAIL low_freeze: dut=%h want %h", dut_vec, frozen);
        end
    endtask

    task automatic test_restart();
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        tests++;
        if (dead !== 1'b0 || start !== 1'b0 || map !== 16'h0 || score !== to_bcd(m_score) || score === 32'h0) begin
            fails++; $display("FAIL restart_idle: dead=%b start=%b map=%h score=%h want 0/0/0/%h", dead, start, map, score, to_bcd(m_score));
        end
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        tests++;
        if (start !== 1'b1 || score !== 32'h0) begin
            fails++; $display("FAIL restart_run: start=%b score=%h want 1/0", start, score);
        end
    endtask

    task automatic test_jump_over();
        int n, len;
        begin_game();
        n = 0;
        while (jump !== 1'b1 && n < 200) begin
            step(1'b0, 1'b0, bot_press(0));
            n++;
        end
        len = 0;
        while (jump === 1'b1 && len < 20) begin
            len++;
            step(1'b0, 1'b0, bot_press(0));
            tests++;
            if (dut_vec !== m_vec()) begin
                fails++; $display("FAIL jump_track: dut=%h model=%h", dut_vec, m_vec());
            end
        end
        tests++;
        if (len != 5 || dead !== 1'b0) begin
            fails++; $display("FAIL jump_length: airborne=%0d cycles dead=%b want 5/0", len, dead);
        end
        repeat (16) step(1'b0, 1'b0, bot_press(0));
        tests++;
        if (dead !== 1'b0 || score !== to_bcd(m_score)) begin
            fails++; $display("FAIL jump_survive: dead=%b score=%h want 0/%h", dead, score, to_bcd(m_score));
        end
    endtask

    task automatic test_bcd_carry();
        int n;
        logic [31:0] prev;
        begin_game();
        n = 0;
        prev = '0;
        while (score !== 32'h0000_0100 && n < 700) begin
            prev = score;
            step(1'b0, 1'b0, bot_press(0));
            n++;
            tests++;
            if (dut_vec !== m_vec()) begin
                fails++; $display("FAIL bcd_track: dut=%h model=%h", dut_vec, m_vec());
            end
        end
        tests++;
        if (score !== 32'h0000_0100 || prev !== 32'h0000_0099) begin
            fails++; $display("FAIL bcd_carry: prev=%h score=%h want 00000099 -> 00000100", prev, score);
        end
    endtask

    task automatic test_high_airborne();
        int n;
        begin_game();
        n = 0;
        while (dead !== 1'b1 && n < 2000) begin
            step(1'b0, 1'b0, bot_press(2));
            n++;
            tests++;
            if (dut_vec !== m_vec()) begin
                fails++; $display("FAIL high_track: dut=%h model=%h", dut_vec, m_vec());
            end
        end
        tests++;
        if (dead !== 1'b1 || map[15:14] !== 2'd2 || jump !== 1'b1) begin
            fails++; $display("FAIL high_hit: dead=%b cell7=%0d jump=%b want 1/2/1", dead, map[15:14], jump);
        end
    endtask

    task automatic test_simultaneous();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        tests++;
        if (start !== 1'b1 || jump !== 1'b0) begin
            fails++; $display("FAIL start_beats_jump: start=%b jump=%b want 1/0", start, jump);
        end
    endtask

    task automatic test_midgame_reset();
        begin_game();
        repeat (60) step(1'b0, 1'b0, bot_press(0));
        step(1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec !== 51'd0) begin
            fails++; $display("FAIL midgame_reset: got %h want 0", dut_vec);
        end
    endtask

    task automatic test_random();
        int mode;
        bit ps, rs;
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
            rs = ($urandom_range(0, 499) == 0);
            ps = !last_ps && ($urandom_range(0, 29) == 0);
            step(rs, ps, bot_press(mode));
            tests++;
            if (dut_vec !== m_vec()) begin
                fails++; $display("FAIL random_track: cycle %0d dut=%h model=%h", c, dut_vec, m_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; btn_start = 1'b0; btn_jump = 1'b0;
        last_ps = 1'b0; last_pj = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0);
        @(negedge CLK100MHZ);
        test_reset();
        test_start();
        test_collision_low();
        test_restart();
        test_jump_over();
        test_bcd_carry();
        test_high_airborne();
        test_simultaneous();
        test_midgame_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
